// File: rtl/uart_core.sv
// uart_core: full-duplex UART with baud divider, configurable frame and mid-bit sampling RX.
// Define UART_PARITY_EN to insert/check a parity bit and expose rx_parity_err_o.
module uart_core #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 txd_o,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
`ifdef UART_PARITY_EN
    output logic                 rx_parity_err_o,
`endif
    output logic                 rx_frame_err_o
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 2);
    localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CntW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (tx_valid_i) begin
                    tx_state_d = TxStart;
                    tx_sh_d    = tx_data_i;
                    tx_par_d   = (^tx_data_i) ^ PARITY_ODD;
                    tx_bit_d   = '0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CntMax) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                end
            end
            TxData: begin
                if (tx_cnt_q == CntMax) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = tx_sh_q >> 1;
                    if (tx_bit_q == DataLast) begin
                        tx_bit_d   = '0;
                        tx_state_d = ParEn ? TxParity : TxStop;
                    end else begin
                        tx_bit_d = tx_bit_q + BitW'(1);
                    end
                end
            end
            TxParity: begin
                if (tx_cnt_q == CntMax) begin
                    tx_state_d = TxStop;
                    tx_cnt_d   = '0;
                end
            end
            TxStop: begin
                // Last stop bit ends one cycle early: the idle cycle completes it on the line.
                if (tx_bit_q == StopLast && tx_cnt_q == CntLast) begin
                    tx_state_d = TxIdle;
                    tx_cnt_d   = '0;
                end else if (tx_cnt_q == CntMax) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + BitW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        tx_ready_o = 1'b0;
        txd_o      = 1'b1;
        case (tx_state_q)
            TxIdle:   tx_ready_o = 1'b1;
            TxStart:  txd_o = 1'b0;
            TxData:   txd_o = tx_sh_q[0];
            TxParity: txd_o = tx_par_q;
            default:  txd_o = 1'b1;
        endcase
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                 rx_par_q, rx_par_d, rx_par_bad, rx_sample;
    logic                 rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
    logic                 rx_perr_q, rx_perr_d;
`endif

    assign rx_s       = rx_sync_q[1];
    assign rx_sample  = (rx_cnt_q == CntMax);
    assign rx_par_bad = ParEn && ((rx_par_q ^ (^rx_sh_q)) != PARITY_ODD);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state_q <= RxIdle;
            rx_sync_q  <= 2'b11;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_sync_q  <= {rx_sync_q[0], rxd_i};
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_s) rx_state_d = RxStart;
            end
            RxStart: begin
                // Re-check at mid start bit so short glitches fall back to idle.
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_sample) begin
                    rx_cnt_d = '0;
                    if (rx_bit_q == DataLast) begin
                        rx_bit_d   = '0;
                        rx_state_d = ParEn ? RxParity : RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + BitW'(1);
                    end
                end
            end
            RxParity: begin
                if (rx_sample) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_sample) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? RxIdle : RxWaitHigh;
                end
            end
            RxWaitHigh: begin
                rx_cnt_d = '0;
                if (rx_s) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_d  = 1'b0;
`endif
        case (rx_state_q)
            RxData:   if (rx_sample) rx_sh_d = {rx_s, rx_sh_q[DATA_BITS-1:1]};
            RxParity: if (rx_sample) rx_par_d = rx_s;
            RxStop: begin
                if (rx_sample) begin
                    if (!rx_s) begin
                        rx_ferr_d = 1'b1;
                    end else if (rx_par_bad) begin
`ifdef UART_PARITY_EN
                        rx_perr_d = 1'b1;
`endif
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign rx_frame_err_o = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err_o = rx_perr_q;
`endif
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized directed bench for uart_core with a frame-level reference model.
// Parity scenarios run only when UART_PARITY_EN is defined.
module tb_uart_core;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + 8 + P + 1;
    localparam int F = NBITS * CPB;

    logic       clk, rst_n, tx_valid, tx_ready, txd, rxd, rx_valid, rx_ferr, rx_perr;
    logic [7:0] tx_data, rx_data;
    logic       loop, rxd_drv;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_excl = 0, n_wide = 0;
    logic prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_data;

    assign rxd = loop ? txd : rxd_drv;

    uart_core #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .txd_o          (txd),
        .rxd_i          (rxd),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
`ifdef UART_PARITY_EN
        .rx_parity_err_o(rx_perr),
`endif
        .rx_frame_err_o (rx_ferr)
    );
`ifndef UART_PARITY_EN
    assign rx_perr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid++;
            rx_q.push_back(rx_data);
        end
        if (rx_ferr === 1'b1) n_ferr++;
        if (rx_perr === 1'b1) n_perr++;
        if (rx_valid === 1'b1 && (rx_ferr === 1'b1 || rx_perr === 1'b1)) n_excl++;
        if ((rx_valid === 1'b1 && prev_v) || (rx_ferr === 1'b1 && prev_f) ||
            (rx_perr === 1'b1 && prev_p)) n_wide++;
        prev_v = (rx_valid === 1'b1);
        prev_f = (rx_ferr === 1'b1);
        prev_p = (rx_perr === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line bits of one frame, index 0 = start bit.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit bad_par,
                                               input bit stop);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (P == 1) f[9] = (^d) ^ bad_par;
        f[9 + P] = stop;
        return f;
    endfunction

    task automatic drive_frame(input logic [15:0] f);
        for (int i = 0; i < NBITS; i++) begin
            rxd_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e, a;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check(tag, {24'h0, a}, {24'h0, e});
        end
        rx_q.delete();
    endtask

    // Sends one byte and compares txd/tx_ready against the frame model every cycle.
    task automatic tx_check(input logic [7:0] d);
        logic [15:0] f;
        int bad_txd, bad_rdy;
        f       = frame_bits(d, 1'b0, 1'b1);
        bad_txd = 0;
        bad_rdy = 0;
        check("tx_ready_before", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= F; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom_range(0, 255));
            end
            if (txd !== f[(k - 1) / CPB]) bad_txd++;
            if (tx_ready !== (k == F)) bad_rdy++;
        end
        check("tx_frame_bits", bad_txd, 0);
        check("tx_ready_timing", bad_rdy, 0);
        exp_q.push_back(d);
        exp_rx_data = d;
    endtask

    initial begin
        int ready_hi, v0, f0, p0;
        logic [7:0] b;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; loop = 1'b0; rxd_drv = 1'b1;
        exp_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_ferr", rx_ferr, 0);
        check("rst_rx_perr", rx_perr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // TX 0xA5 and random bytes, looped back into RX
        loop = 1'b1;
        tx_check(8'hA5);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tx_check(8'($urandom_range(0, 255)));
        end
        repeat (2 * CPB) @(negedge clk);
        check_rx("tx_loop_rx");
        check("tx_loop_rx_data", rx_data, exp_rx_data);

        // Back-to-back 0x3C, 0xFF
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        ready_hi = 0;
        for (int k = 1; k <= F + 1; k++) begin
            @(negedge clk);
            if (k == 1) tx_data = 8'hFF;
            if (tx_ready === 1'b1) ready_hi++;
            if (k == F) check("b2b_ready_at_F", tx_ready, 1);
            if (k == F + 1) begin
                check("b2b_second_start", txd, 0);
                tx_valid = 1'b0;
            end
        end
        check("b2b_ready_width", ready_hi, 1);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        exp_rx_data = 8'hFF;
        repeat (2 * F) @(negedge clk);
        check_rx("b2b_rx");
        check("b2b_rx_data", rx_data, exp_rx_data);

        // Random frames driven straight onto rxd
        loop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            drive_frame(frame_bits(b, 1'b0, 1'b1));
            exp_q.push_back(b);
            exp_rx_data = b;
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (2 * CPB) @(negedge clk);
        check_rx("rand_rx");
        check("rand_rx_data", rx_data, exp_rx_data);

        // One-cycle glitch on rxd
        v0 = n_valid; f0 = n_ferr;
        rxd_drv = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);
        b = 8'($urandom_range(0, 255));
        drive_frame(frame_bits(b, 1'b0, 1'b1));
        exp_q.push_back(b);
        exp_rx_data = b;
        repeat (2 * CPB) @(negedge clk);
        check_rx("glitch_then_rx");

        // Framing error followed by 20 low cycles, then a good 0x12
        v0 = n_valid; f0 = n_ferr;
        drive_frame(frame_bits(8'h55, 1'b0, 1'b0));
        repeat (20) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("ferr_one_pulse", n_ferr - f0, 1);
        check("ferr_no_valid", n_valid - v0, 0);
        check("ferr_rx_data_held", rx_data, exp_rx_data);
        drive_frame(frame_bits(8'h12, 1'b0, 1'b1));
        exp_q.push_back(8'h12);
        exp_rx_data = 8'h12;
        repeat (2 * CPB) @(negedge clk);
        check_rx("ferr_then_rx");
        check("ferr_then_rx_data", rx_data, exp_rx_data);

`ifdef UART_PARITY_EN
        // Parity: model covers the parity bit and 44-cycle frame; then a corrupted parity bit
        loop = 1'b1;
        tx_check(8'hA5);
        repeat (2 * CPB) @(negedge clk);
        check_rx("par_tx_rx");
        loop = 1'b0;
        v0 = n_valid; p0 = n_perr;
        drive_frame(frame_bits(8'hA5, 1'b1, 1'b1));
        repeat (2 * CPB) @(negedge clk);
        check("perr_one_pulse", n_perr - p0, 1);
        check("perr_no_valid", n_valid - v0, 0);
        check("perr_rx_data_held", rx_data, exp_rx_data);
`else
        p0 = n_perr;
        check("no_perr_without_parity", n_perr - p0, 0);
`endif

        // Reset during data bit 3 of 0xA5 in loopback
        loop = 1'b1;
        v0 = n_valid;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 1 + 4 * CPB + 1; k++) begin
            @(negedge clk);
            if (k == 1) tx_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_txd", txd, 1);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_rx_data", rx_data, 0);
        rst_n = 1'b1;
        exp_rx_data = 8'h00;
        repeat (2 * F) @(negedge clk);
        check("rst_mid_no_valid", n_valid - v0, 0);
        check("rst_mid_rx_data_after", rx_data, exp_rx_data);
        check("rst_mid_idle_txd", txd, 1);

        check("pulse_exclusive", n_excl, 0);
        check("pulse_one_cycle", n_wide, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
